// File: rtl/intr_pkg.sv
// ============================================================================
// Module   : intr_pkg
// Brief    : Shared types and constants for the 8-input interrupt controller.
//            Optional feature macro: INTR_ROUND_ROBIN_EN (used by the top).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intr_pkg;

    localparam int N   = 8;
    localparam int IDW = 3;

    localparam logic [N-1:0] MASK_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/prio_sel_8.sv
// ============================================================================
// Module   : prio_sel_8
// Brief    : Combinational 8-way priority selector. Searches downward from
//            'start' with wrap (start, start-1, ..., 0, 7, ...) and returns
//            the first set bit of 'vec'.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_sel_8
    import intr_pkg::*;
(
    input  logic [N-1:0]   vec,
    input  logic [IDW-1:0] start,
    output logic [IDW-1:0] id,
    output logic           valid
);

    logic [IDW-1:0] w_idx;

    // Walk from the lowest-priority position up to 'start' so the last hit,
    // i.e. the one closest to 'start', wins.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = start - IDW'(k);
            if (vec[w_idx]) begin
                id    = w_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intr_prio_ctrl_8.sv
// ============================================================================
// Module   : intr_prio_ctrl_8
// Brief    : 8-input edge-triggered interrupt controller with software mask,
//            priority selection and irq/ack/eoi handshake with the CPU.
//            Optional macro INTR_ROUND_ROBIN_EN: rotating priority where the
//            last acknowledged source drops to lowest priority. Undefined:
//            fixed priority, bit 7 highest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_prio_ctrl_8 #(
    parameter int N   = 8,   // only 8 is supported
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           mask_we,
    input  logic [N-1:0]   mask_wdata,
    input  logic           ack,
    input  logic           eoi,
    output logic           irq,
    output logic [IDW-1:0] irq_id,
    output logic           busy,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   mask
);

    import intr_pkg::*;

    state_t         r_state;
    logic [N-1:0]   r_req_q;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_mask;
    logic           r_irq;
    logic           r_busy;
    logic [IDW-1:0] r_irq_id;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_clr;
    logic           w_ack_take;
    logic [IDW-1:0] w_start;
    logic [IDW-1:0] w_sel_id;
    logic           w_sel_valid;

    assign w_edge     = req & ~r_req_q;
    assign w_ack_take = (r_state == ASSERT) && ack;
    // Clear of the acknowledged bit; a coincident new edge re-sets it below.
    assign w_clr      = w_ack_take ? ({{(N-1){1'b0}}, 1'b1} << r_irq_id) : '0;

`ifdef INTR_ROUND_ROBIN_EN
    logic [IDW-1:0] r_last_id;

    // Remember the last acknowledged source so it becomes lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id <= IDW'(N - 1);
        end else if (w_ack_take) begin
            r_last_id <= r_irq_id;
        end
    end

    assign w_start = r_last_id - IDW'(1);
`else
    assign w_start = IDW'(N - 1);
`endif

    prio_sel_8 u_prio_sel (
        .vec   (r_pending & ~r_mask),
        .start (w_start),
        .id    (w_sel_id),
        .valid (w_sel_valid)
    );

    // Edge capture, pending bookkeeping and mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // Handshake state machine with registered irq/irq_id/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en && w_sel_valid) begin
                        r_irq    <= 1'b1;
                        r_irq_id <= w_sel_id;
                        r_state  <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack) begin
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SERVICE;
                    end else if (!en) begin
                        r_irq   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq     = r_irq;
    assign irq_id  = r_irq_id;
    assign busy    = r_busy;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule

`default_nettype wire
